marfeeder: RTL and testbench
============================

# marfeeder

Sequencer-side writer for the marbuffer timed-output FIFOs. It takes a stream of 32-bit instruction words from the sequencer memory over a valid/ready handshake and decodes each word into a write, direct, wait or halt operation. It dispatches writes and directs to one of `N_BUF` marbuffer instances, pacing writes against their full flags. It also aggregates buffer overflow errors into sticky status bits.

## Interface
- `N_BUF`, 4: number of downstream marbuffers (1..32).
- `HOLDOFF`, 2: minimum idle cycles after a write strobe to target t before the next write to t; covers marbuffer full-flag latency.
- `clk`  in  1  system clock; everything on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  leave IDLE/HALTED and run; clears sticky errors.
- `stop_i`  in  1  abort to IDLE from any state.
- `word_i`  in  32  instruction word.
- `word_valid_i`  in  1  `word_i` valid.
- `word_ready_o`  out  1  word accepted when valid && ready.
- `data_o`  out  16  data to all buffers (`data_i`).
- `delay_o`  out  7  delay to all buffers (`delay_i`).
- `valid_o`  out  N_BUF  one-hot, single-cycle write strobe.
- `direct_o`  out  N_BUF  one-hot, single-cycle direct strobe.
- `full_i`  in  N_BUF  marbuffer `full_o` flags.
- `err_i`  in  N_BUF  marbuffer `err_o` strobes.
- `err_o`  out  2  sticky: [0] bad target index, [1] buffer overflow.
- `halted_o`  out  1  high in HALTED.
- `state_o`  out  3  current state, for debug readback.

## Operation
- Word fields:
  - [31:30] op: 0 WAIT, 1 WRITE, 2 DIRECT, 3 HALT.
  - [29:25] target.
  - [24:23] reserved; ignored.
  - [22:16] delay.
  - [15:0] data.
  - WAIT uses [22:0] as a 23-bit cycle count.
- States:
  - IDLE (reset): `start_i` -> RUN.
  - RUN: `word_ready_o`=1. It is combinational and equal to (state==RUN). Decode on accept.
  - BLOCK: holds one pending WRITE. Leaves when `full_i[t]`==0 and `holdoff[t]`==0.
  - COUNT: WAIT countdown.
  - HALTED: `start_i` -> RUN.
- WRITE to t < N_BUF, t not full, `holdoff[t]`==0:
  - next cycle `valid_o[t]`=1 and data/delay driven.
  - `holdoff[t]` loads `HOLDOFF`.
  - stay in RUN.
- WRITE to t blocked by full or holdoff: latch word, go to BLOCK. Strobe on the cycle after clearing, then return to RUN.
- DIRECT to t < N_BUF: next cycle `direct_o[t]`=1 with data. Ignores full and holdoff; stay in RUN.
- Any op with t >= N_BUF: word dropped, `err_o[0]` set, stay in RUN.
- WAIT, count 0: no-op. Count n>0: go to COUNT; `word_ready_o` low for exactly n cycles after the accept cycle.
- HALT: next cycle HALTED, `halted_o`=1.
- Any `err_i[k]` pulse, in any state, sets `err_o[1]`.
- `start_i` clears `err_o`. Same-cycle new errors win over clear.
- `stop_i`:
  - next state IDLE, drop pending word, cancel COUNT, no strobe.
  - `stop_i` beats `start_i` when both are high.
  - holdoff counters keep decrementing.
- `data_o`/`delay_o` hold their last value between strobes.
- At most one bit of `valid_o` | `direct_o` is set per cycle.

## Timing
- All outputs registered except `word_ready_o`.
- Reset values: all strobes 0, `data_o`=0, `delay_o`=0, `err_o`=0, `halted_o`=0, `state_o`=IDLE, `word_ready_o`=0, holdoff counters 0.
- Reset asserted mid-operation clears the above asynchronously. A pending word is lost.
- Accept at cycle c -> strobe at c+1.
- Throughput:
  - different targets: one strobe per cycle.
  - same target: one write per `HOLDOFF`+1 cycles.
  - directs to the same target: back-to-back allowed.
- Holdoff counters are 0..HOLDOFF, saturate at 0, one per target.
- WAIT count is 23-bit unsigned, no wrap. n=2^23-1 is legal.
- BLOCK exit: first cycle with the condition true is e; strobe at e+1; `word_ready_o`=1 at e+1.

## Structure
- Package `marfeeder_pkg`:
  - op enum (`OP_WAIT`, `OP_WRITE`, `OP_DIRECT`, `OP_HALT`).
  - state enum.
  - field LSB/MSB constants.
  - err bit indices.
- Sub-module `marfeeder_holdoff`: one per-target down-counter with load and zero flag, instantiated `N_BUF` times via generate.

## Test plan
- start; WRITE t=1 delay=5 data=0xBEEF accepted at c:
  - `valid_o`=4'b0010 at c+1 only, `delay_o`=5, `data_o`=0xBEEF.
  - `word_ready_o` stays 1.
- Three back-to-back WRITEs to t=0, `HOLDOFF`=2:
  - `valid_o[0]` strobes at c+1, c+4, c+7.
  - ready low in the gap cycles.
- `full_i[2]`=1 with WRITE t=2 pending:
  - state BLOCK, no strobe.
  - deassert full at e -> strobe at e+1, one only.
- WAIT n=10 accepted at c:
  - ready low c+1..c+10, high at c+11.
  - `stop_i` at c+4 -> IDLE at c+5, no further strobes.
- Error paths:
  - WRITE t=7 with `N_BUF`=4 -> `err_o`=2'b01, no strobe.
  - `err_i[3]` pulse -> `err_o`=2'b11.
  - `start_i` -> `err_o`=0.
- HALT then `start_i`; and `rst_n` low during BLOCK:
  - HALT: `halted_o` 1 until start, then RUN.
  - reset: all outputs at reset values immediately, IDLE after release.

Source files
------------

// File: rtl/marfeeder_pkg.sv
// marfeeder_pkg: shared types and constants for the marbuffer feeder.
//   op_e    - instruction opcode in word[31:30]
//   state_e - feeder FSM state, exported on state_o
//   *_MSB/*_LSB - instruction word field positions
//   ERR_*   - bit positions inside err_o
package marfeeder_pkg;

  typedef enum logic [1:0] {
    OP_WAIT   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_DIRECT = 2'd2,
    OP_HALT   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_BLOCK  = 3'd2,
    ST_COUNT  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 30;
  localparam int unsigned TGT_MSB  = 29;
  localparam int unsigned TGT_LSB  = 25;
  localparam int unsigned DLY_MSB  = 22;
  localparam int unsigned DLY_LSB  = 16;
  localparam int unsigned DATA_MSB = 15;
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned CNT_MSB  = 22;
  localparam int unsigned CNT_LSB  = 0;

  localparam int unsigned ERR_TGT = 0;
  localparam int unsigned ERR_OVF = 1;

endpackage

// File: rtl/marfeeder_if.sv
// marfeeder_if: instruction stream plus marbuffer write bus.
//   word_i/word_valid_i/word_ready_o - instruction handshake
//   data_o/delay_o                   - shared buffer payload
//   valid_o/direct_o                 - one-hot per-buffer strobes
//   full_i/err_i                     - per-buffer status
// slave modport is the feeder's view; master is the environment's.
interface marfeeder_if #(
  parameter int unsigned N_BUF = 4
) ();
  logic [31:0]      word_i;
  logic             word_valid_i;
  logic             word_ready_o;
  logic [15:0]      data_o;
  logic [6:0]       delay_o;
  logic [N_BUF-1:0] valid_o;
  logic [N_BUF-1:0] direct_o;
  logic [N_BUF-1:0] full_i;
  logic [N_BUF-1:0] err_i;

  modport slave (
    input  word_i, word_valid_i, full_i, err_i,
    output word_ready_o, data_o, delay_o, valid_o, direct_o
  );

  modport master (
    output word_i, word_valid_i, full_i, err_i,
    input  word_ready_o, data_o, delay_o, valid_o, direct_o
  );
endinterface

// File: rtl/marfeeder_holdoff.sv
// marfeeder_holdoff: per-target write holdoff down-counter.
//   load_i - reload to HOLDOFF (takes priority over decrement)
//   zero_o - counter is 0; a write to this target may issue
// Counts down by one per cycle and saturates at 0.
module marfeeder_holdoff #(
  parameter int unsigned HOLDOFF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic zero_o
);
  localparam int unsigned CW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(HOLDOFF);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/marfeeder.sv
// marfeeder: decodes sequencer instruction words and dispatches writes /
// directs to N_BUF marbuffers, pacing writes against full flags and a
// per-target holdoff.
//   clk, rst_n       - clock, async active-low reset
//   start_i, stop_i  - run control (stop wins); start clears err_o
//   bus              - instruction handshake and buffer bus (slave)
//   err_o            - sticky {overflow, bad target}
//   halted_o         - in HALTED
//   state_o          - current FSM state
module marfeeder
  import marfeeder_pkg::*;
#(
  parameter int unsigned N_BUF   = 4,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        stop_i,
  marfeeder_if.slave  bus,
  output logic [1:0]  err_o,
  output logic        halted_o,
  output logic [2:0]  state_o
);
  state_e           state_q, state_d;
  logic [27:0]      pend_q, pend_d;      // {tgt, delay, data} of a blocked WRITE
  logic [22:0]      cnt_q, cnt_d;
  logic [N_BUF-1:0] valid_q, valid_d, direct_q, direct_d;
  logic [15:0]      data_q, data_d;
  logic [6:0]       delay_q, delay_d;
  logic [1:0]       err_q, err_d;
  logic             halted_q, halted_d;

  op_e              op;
  logic [4:0]       tgt;
  logic [6:0]       dly;
  logic [15:0]      dat;
  logic [N_BUF-1:0] tgt_oh, hold_zero;
  logic             tgt_ok, full_hit, hold_hit, bad_tgt;

  for (genvar g = 0; g < int'(N_BUF); g++) begin : g_hold
    marfeeder_holdoff #(.HOLDOFF(HOLDOFF)) u_hold (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (valid_d[g]),
      .zero_o (hold_zero[g])
    );
  end

  // In BLOCK the target/payload come from the latched word, otherwise
  // from the live input word.
  always_comb begin
    op = op_e'(bus.word_i[OP_MSB:OP_LSB]);
    if (state_q == ST_BLOCK) begin
      tgt = pend_q[27:23];
      dly = pend_q[22:16];
      dat = pend_q[15:0];
    end else begin
      tgt = bus.word_i[TGT_MSB:TGT_LSB];
      dly = bus.word_i[DLY_MSB:DLY_LSB];
      dat = bus.word_i[DATA_MSB:DATA_LSB];
    end
    for (int unsigned i = 0; i < N_BUF; i++) begin
      tgt_oh[i] = (tgt == 5'(i));
    end
    tgt_ok   = (32'(tgt) < N_BUF);
    full_hit = |(tgt_oh & bus.full_i);
    hold_hit = |(tgt_oh & ~hold_zero);
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    valid_d  = '0;
    direct_d = '0;
    data_d   = data_q;
    delay_d  = delay_q;
    bad_tgt  = 1'b0;

    if (stop_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (start_i) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (bus.word_valid_i) begin
            if (!tgt_ok) begin
              bad_tgt = 1'b1;
            end else begin
              unique case (op)
                OP_WAIT: begin
                  if (bus.word_i[CNT_MSB:CNT_LSB] != '0) begin
                    cnt_d   = bus.word_i[CNT_MSB:CNT_LSB];
                    state_d = ST_COUNT;
                  end
                end
                OP_WRITE: begin
                  if (full_hit || hold_hit) begin
                    pend_d  = {tgt, dly, dat};
                    state_d = ST_BLOCK;
                  end else begin
                    valid_d = tgt_oh;
                    data_d  = dat;
                    delay_d = dly;
                  end
                end
                OP_DIRECT: begin
                  direct_d = tgt_oh;
                  data_d   = dat;
                  delay_d  = dly;
                end
                OP_HALT: state_d = ST_HALTED;
                default: ;
              endcase
            end
          end
        end
        ST_BLOCK: begin
          if (!full_hit && !hold_hit) begin
            valid_d = tgt_oh;
            data_d  = dat;
            delay_d = dly;
            state_d = ST_RUN;
          end
        end
        ST_COUNT: begin
          // Leaving on cnt==1 keeps ready low for exactly n cycles.
          if (cnt_q <= 23'd1) state_d = ST_RUN;
          else                cnt_d   = cnt_q - 23'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Fresh errors win over the start-induced clear.
    err_d          = start_i ? 2'b00 : err_q;
    err_d[ERR_TGT] = err_d[ERR_TGT] | bad_tgt;
    err_d[ERR_OVF] = err_d[ERR_OVF] | (|bus.err_i);
    halted_d       = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      cnt_q    <= '0;
      valid_q  <= '0;
      direct_q <= '0;
      data_q   <= '0;
      delay_q  <= '0;
      err_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      direct_q <= direct_d;
      data_q   <= data_d;
      delay_q  <= delay_d;
      err_q    <= err_d;
      halted_q <= halted_d;
    end
  end

  assign bus.word_ready_o = (state_q == ST_RUN);
  assign bus.valid_o      = valid_q;
  assign bus.direct_o     = direct_q;
  assign bus.data_o       = data_q;
  assign bus.delay_o      = delay_q;
  assign err_o            = err_q;
  assign halted_o         = halted_q;
  assign state_o          = state_q;
endmodule

// File: tb/tb_marfeeder.sv
// tb_marfeeder: directed bench for marfeeder with N_BUF=4, HOLDOFF=2.
module tb_marfeeder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i, stop_i;
  logic [1:0] err_o;
  logic       halted_o;
  logic [2:0] state_o;
  int         n_cmp = 0;
  int         n_bad = 0;

  marfeeder_if #(.N_BUF(4)) bus ();

  marfeeder #(.N_BUF(4), .HOLDOFF(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .stop_i   (stop_i),
    .bus      (bus),
    .err_o    (err_o),
    .halted_o (halted_o),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkw(input logic [1:0] op, input logic [4:0] t,
                                      input logic [6:0] d, input logic [15:0] x);
    return {op, t, 2'b00, d, x};
  endfunction

  function automatic logic [31:0] mkwait(input logic [22:0] n);
    return {2'b00, 5'd0, 2'b00, n};
  endfunction

  initial begin
    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    bus.word_i = '0; bus.word_valid_i = 1'b0; bus.full_i = '0; bus.err_i = '0;

    // Reset values
    #2;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ready", 32'(bus.word_ready_o), 32'd0);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_direct", 32'(bus.direct_o), 32'd0);
    chk("rst_data", 32'(bus.data_o), 32'd0);
    chk("rst_delay", 32'(bus.delay_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_halted", 32'(halted_o), 32'd0);
    #10 rst_n = 1'b1;
    tick();
    chk("idle_state", 32'(state_o), 32'd0);

    // Start
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("run_state", 32'(state_o), 32'd1);
    chk("run_ready", 32'(bus.word_ready_o), 32'd1);

    // Single WRITE t=1 delay=5 data=BEEF
    bus.word_i = mkw(2'd1, 5'd1, 7'd5, 16'hBEEF); bus.word_valid_i = 1'b1;
    tick(); bus.word_valid_i = 1'b0;
    chk("w1_valid", 32'(bus.valid_o), 32'h2);
    chk("w1_delay", 32'(bus.delay_o), 32'd5);
    chk("w1_data", 32'(bus.data_o), 32'hBEEF);
    chk("w1_ready", 32'(bus.word_ready_o), 32'd1);
    tick();
    chk("w1_valid_off", 32'(bus.valid_o), 32'd0);
    chk("w1_data_hold", 32'(bus.data_o), 32'hBEEF);

    // Three WRITEs to t=0: strobes at c+1, c+4, c+7
    bus.word_i = mkw(2'd1, 5'd0, 7'd1, 16'h0001); bus.word_valid_i = 1'b1;
    tick();
    chk("h_s1", 32'(bus.valid_o), 32'h1);
    chk("h_s1_data", 32'(bus.data_o), 32'h0001);
    chk("h_rdy_c1", 32'(bus.word_ready_o), 32'd1);
    bus.word_i = mkw(2'd1, 5'd0, 7'd2, 16'h0002);
    tick(); bus.word_valid_i = 1'b0;
    chk("h_block", 32'(state_o), 32'd2);
    chk("h_rdy_c2", 32'(bus.word_ready_o), 32'd0);
    chk("h_gap_c2", 32'(bus.valid_o), 32'd0);
    tick();
    chk("h_rdy_c3", 32'(bus.word_ready_o), 32'd0);
    chk("h_gap_c3", 32'(bus.valid_o), 32'd0);
    tick();
    chk("h_s2", 32'(bus.valid_o), 32'h1);
    chk("h_s2_data", 32'(bus.data_o), 32'h0002);
    chk("h_rdy_c4", 32'(bus.word_ready_o), 32'd1);
    bus.word_i = mkw(2'd1, 5'd0, 7'd3, 16'h0003); bus.word_valid_i = 1'b1;
    tick(); bus.word_valid_i = 1'b0;
    chk("h_rdy_c5", 32'(bus.word_ready_o), 32'd0);
    chk("h_gap_c5", 32'(bus.valid_o), 32'd0);
    tick();
    chk("h_rdy_c6", 32'(bus.word_ready_o), 32'd0);
    tick();
    chk("h_s3", 32'(bus.valid_o), 32'h1);
    chk("h_s3_data", 32'(bus.data_o), 32'h0003);
    tick();
    chk("h_s3_off", 32'(bus.valid_o), 32'd0);

    // WRITE to full target 2
    bus.full_i = 4'b0100;
    bus.word_i = mkw(2'd1, 5'd2, 7'd7, 16'h1234); bus.word_valid_i = 1'b1;
    tick(); bus.word_valid_i = 1'b0;
    chk("f_block", 32'(state_o), 32'd2);
    chk("f_nostrobe1", 32'(bus.valid_o), 32'd0);
    tick();
    chk("f_nostrobe2", 32'(bus.valid_o), 32'd0);
    bus.full_i = 4'b0000;
    tick();
    chk("f_strobe", 32'(bus.valid_o), 32'h4);
    chk("f_data", 32'(bus.data_o), 32'h1234);
    chk("f_delay", 32'(bus.delay_o), 32'd7);
    chk("f_ready", 32'(bus.word_ready_o), 32'd1);
    tick();
    chk("f_once", 32'(bus.valid_o), 32'd0);

    // WAIT n=10: ready low c+1..c+10, high c+11
    bus.word_i = mkwait(23'd10); bus.word_valid_i = 1'b1;
    tick(); bus.word_valid_i = 1'b0;
    chk("wt_count", 32'(state_o), 32'd3);
    for (int i = 1; i <= 10; i++) begin
      chk("wt_rdy_low", 32'(bus.word_ready_o), 32'd0);
      tick();
    end
    chk("wt_rdy_high", 32'(bus.word_ready_o), 32'd1);

    // WAIT n=10 aborted by stop at c+4
    bus.word_i = mkwait(23'd10); bus.word_valid_i = 1'b1;
    tick(); bus.word_valid_i = 1'b0;
    tick(); tick(); tick();
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    chk("stop_idle", 32'(state_o), 32'd0);
    chk("stop_rdy", 32'(bus.word_ready_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stop_nostrobe", 32'(bus.valid_o | bus.direct_o), 32'd0);
      tick();
    end

    // Error paths and directs
    start_i = 1'b1; tick(); start_i = 1'b0;
    bus.word_i = mkw(2'd1, 5'd7, 7'd1, 16'h5555); bus.word_valid_i = 1'b1;
    tick(); bus.word_valid_i = 1'b0;
    chk("bad_nostrobe", 32'(bus.valid_o), 32'd0);
    chk("bad_err", 32'(err_o), 32'h1);
    chk("bad_run", 32'(state_o), 32'd1);
    bus.word_i = mkw(2'd2, 5'd3, 7'd9, 16'h00AA); bus.word_valid_i = 1'b1;
    tick();
    chk("d1_direct", 32'(bus.direct_o), 32'h8);
    chk("d1_data", 32'(bus.data_o), 32'h00AA);
    bus.word_i = mkw(2'd2, 5'd3, 7'd9, 16'h00BB);
    tick(); bus.word_valid_i = 1'b0;
    chk("d2_direct", 32'(bus.direct_o), 32'h8);
    chk("d2_data", 32'(bus.data_o), 32'h00BB);
    chk("d2_novalid", 32'(bus.valid_o), 32'd0);
    bus.err_i = 4'b1000; tick(); bus.err_i = '0;
    chk("ovf_err", 32'(err_o), 32'h3);
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("clr_err", 32'(err_o), 32'h0);

    // HALT then start
    bus.word_i = mkw(2'd3, 5'd0, 7'd0, 16'h0000); bus.word_valid_i = 1'b1;
    tick(); bus.word_valid_i = 1'b0;
    chk("halt_flag", 32'(halted_o), 32'd1);
    chk("halt_state", 32'(state_o), 32'd4);
    chk("halt_rdy", 32'(bus.word_ready_o), 32'd0);
    tick();
    chk("halt_hold", 32'(halted_o), 32'd1);
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("unhalt_flag", 32'(halted_o), 32'd0);
    chk("unhalt_state", 32'(state_o), 32'd1);

    // Reset during BLOCK
    bus.full_i = 4'b0001; bus.err_i = 4'b0001;
    bus.word_i = mkw(2'd1, 5'd0, 7'd4, 16'hCAFE); bus.word_valid_i = 1'b1;
    tick(); bus.word_valid_i = 1'b0; bus.err_i = '0;
    chk("rb_block", 32'(state_o), 32'd2);
    chk("rb_err", 32'(err_o), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("rb_state", 32'(state_o), 32'd0);
    chk("rb_ready", 32'(bus.word_ready_o), 32'd0);
    chk("rb_err0", 32'(err_o), 32'd0);
    chk("rb_data", 32'(bus.data_o), 32'd0);
    chk("rb_delay", 32'(bus.delay_o), 32'd0);
    chk("rb_strobes", 32'(bus.valid_o | bus.direct_o), 32'd0);
    chk("rb_halted", 32'(halted_o), 32'd0);
    bus.full_i = '0;
    #2 rst_n = 1'b1;
    tick();
    chk("rb_idle", 32'(state_o), 32'd0);
    chk("rb_lost1", 32'(bus.valid_o), 32'd0);
    tick();
    chk("rb_lost2", 32'(bus.valid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
